// File: rtl/cla_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead adder/subtractor.
package cla_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Number of lookahead groups, which is also the pipeline depth.
  function automatic int cla_ngrp(input int width, input int group);
    return width / group;
  endfunction

  function automatic bit cla_cfg_ok(input int width, input int group);
    return (group > 0) && (width >= group) && ((width % group) == 0);
  endfunction

  // Carry information leaving one group: carry out and carry into the group MSB.
  typedef struct packed {
    logic cout;
    logic cmsb;
  } cla_carry_t;

endpackage

// File: rtl/cla_group.sv
// One GROUP-bit carry-lookahead group: every internal carry is a flat
// generate/propagate sum-of-products of the group carry-in.
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [GROUP-1:0] g;
  logic [GROUP-1:0] p;
  logic [GROUP:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // c[i] = g[i-1] | p[i-1]g[i-2] | ... | p[i-1..0]cin, expanded per bit
  always_comb begin
    logic acc;
    logic prop;
    acc  = 1'b0;
    prop = 1'b1;
    c    = '0;
    c[0] = cin;
    for (int i = 1; i <= GROUP; i++) begin
      acc  = 1'b0;
      prop = 1'b1;
      for (int j = i - 1; j >= 0; j--) begin
        acc  = acc | (prop & g[j]);
        prop = prop & p[j];
      end
      c[i] = acc | (prop & cin);
    end
  end

  assign sum  = p ^ c[GROUP-1:0];
  assign cout = c[GROUP];
  assign cmsb = c[GROUP-1];

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined CLA adder/subtractor: one lookahead group per stage, carry
// registered between stages, single global stall enable for the whole pipe.
module cla_pipe_addsub
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int NGRP = cla_ngrp(WIDTH, GROUP);
  localparam logic [WIDTH-1:0] GMASK = WIDTH'({GROUP{1'b1}});

  if (!cla_cfg_ok(WIDTH, GROUP)) begin : g_bad_cfg
    $error("cla_pipe_addsub: WIDTH must be a non-zero multiple of GROUP");
  end

  logic adv;

  // Stage registers, index k is stage k
  logic             vld_p [NGRP];
  logic             cy_p  [NGRP];
  logic             z_p   [NGRP];
  logic             sub_p [NGRP];
  logic [WIDTH-1:0] sum_p [NGRP];
  logic [WIDTH-1:0] a_p   [NGRP];
  logic [WIDTH-1:0] b_p   [NGRP];
  logic             ovf_p;

  // Stage inputs: the previous stage's registers, or the input port for stage 0
  logic             pv    [NGRP];
  logic             pcy   [NGRP];
  logic             pz    [NGRP];
  logic             ps    [NGRP];
  logic [WIDTH-1:0] psum  [NGRP];
  logic [WIDTH-1:0] pa    [NGRP];
  logic [WIDTH-1:0] pb    [NGRP];

  logic [GROUP-1:0] ga    [NGRP];
  logic [GROUP-1:0] gb    [NGRP];
  logic [GROUP-1:0] gs    [NGRP];
  cla_carry_t       gc    [NGRP];
  logic [WIDTH-1:0] nsum  [NGRP];

  assign adv      = out_ready | ~vld_p[NGRP-1];
  assign in_ready = adv;

  for (genvar k = 0; k < NGRP; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign pv[k]   = in_valid;
      assign pa[k]   = in_a;
      assign pb[k]   = in_b;
      assign ps[k]   = (in_sub == OP_SUB);
      assign pcy[k]  = (in_sub == OP_SUB);
      assign psum[k] = '0;
      assign pz[k]   = 1'b1;
    end else begin : g_next
      assign pv[k]   = vld_p[k-1];
      assign pa[k]   = a_p[k-1];
      assign pb[k]   = b_p[k-1];
      assign ps[k]   = sub_p[k-1];
      assign pcy[k]  = cy_p[k-1];
      assign psum[k] = sum_p[k-1];
      assign pz[k]   = z_p[k-1];
    end

    // Subtract inverts B group by group; the +1 is the stage-0 carry-in
    assign ga[k] = pa[k][k*GROUP +: GROUP];
    assign gb[k] = pb[k][k*GROUP +: GROUP] ^ {GROUP{ps[k]}};

    cla_group #(
      .GROUP (GROUP)
    ) u_grp (
      .a    (ga[k]),
      .b    (gb[k]),
      .cin  (pcy[k]),
      .sum  (gs[k]),
      .cout (gc[k].cout),
      .cmsb (gc[k].cmsb)
    );

    assign nsum[k] = (psum[k] & ~(GMASK << (k*GROUP))) | (WIDTH'(gs[k]) << (k*GROUP));
  end

  // Pipeline stage boundary: every stage advances on adv, holds otherwise.
  // Zero is accumulated per group so no stage sees a WIDTH-wide reduction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NGRP; k++) begin
        vld_p[k] <= 1'b0;
        cy_p[k]  <= 1'b0;
        z_p[k]   <= 1'b0;
        sub_p[k] <= 1'b0;
        sum_p[k] <= '0;
        a_p[k]   <= '0;
        b_p[k]   <= '0;
      end
      ovf_p <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < NGRP; k++) begin
        vld_p[k] <= pv[k];
        cy_p[k]  <= gc[k].cout;
        z_p[k]   <= pz[k] & ~|gs[k];
        sub_p[k] <= ps[k];
        sum_p[k] <= nsum[k];
        a_p[k]   <= pa[k];
        b_p[k]   <= pb[k];
      end
      ovf_p <= gc[NGRP-1].cout ^ gc[NGRP-1].cmsb;
    end
  end

  assign out_valid = vld_p[NGRP-1];
  assign out_sum   = sum_p[NGRP-1];
  assign out_cout  = cy_p[NGRP-1];
  assign out_ovf   = ovf_p;
  assign out_zero  = z_p[NGRP-1];

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Bench for cla_pipe_addsub: directed vectors on a 16/4 instance plus randomly
// driven instances of other widths, all scored against an arithmetic model.
module tb_cla_pipe_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Result of a w-bit add/sub as {sum[31:0], cout, ovf, zero}, from plain integer math
  function automatic logic [34:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic s);
    longint mask, half, ua, ub, sa, sb, r, sm;
    logic c, o, z;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua = longint'(a) & mask;
    ub = longint'(b) & mask;
    sa = (ua >= half) ? ua - (half << 1) : ua;
    sb = (ub >= half) ? ub - (half << 1) : ub;
    sm = s ? ((ua - ub) & mask) : ((ua + ub) & mask);
    c  = s ? (ua >= ub) : ((ua + ub) > mask);
    r  = s ? (sa - sb) : (sa + sb);
    o  = (r >= half) || (r < -half);
    z  = (sm == 0);
    return {sm[31:0], c, o, z};
  endfunction

  // ---------------- main 16/4 instance ----------------
  logic        rst = 1'b1;
  logic        rst_c = 1'b1;
  logic        in_valid, in_ready, in_sub, out_valid, out_ready, out_cout, out_ovf, out_zero;
  logic [15:0] in_a, in_b, out_sum;

  cla_pipe_addsub #(.WIDTH(16), .GROUP(4)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero)
  );

  logic [34:0] q16[$];
  logic [34:0] exp16;
  int          ndone = 0;
  logic        stall_prev = 1'b0;
  logic [19:0] held;

  always @(negedge clk) begin
    if (rst) begin
      q16.delete();
      stall_prev = 1'b0;
    end else begin
      chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
      if (stall_prev)
        chk("stall_hold", {out_valid, out_sum, out_cout, out_ovf, out_zero}, held);
      stall_prev = out_valid && !out_ready;
      held = {out_valid, out_sum, out_cout, out_ovf, out_zero};
      if (in_valid && in_ready) q16.push_back(model(16, 32'(in_a), 32'(in_b), in_sub));
      if (out_valid && out_ready) begin
        if (q16.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL spurious_result: got sum 0x%0h, expected no result", out_sum);
        end else begin
          exp16 = q16.pop_front();
          chk("result", {16'h0, out_sum, out_cout, out_ovf, out_zero}, exp16);
          ndone++;
        end
      end
    end
  end

  task automatic directed(input string nm, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic [15:0] es, input logic ec,
                          input logic eo, input logic ez);
    int lat;
    in_a = a; in_b = b; in_sub = s; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk({nm, "_latency"}, lat, 4);
    chk({nm, "_sum"}, out_sum, es);
    chk({nm, "_cout"}, out_cout, ec);
    chk({nm, "_ovf"}, out_ovf, eo);
    chk({nm, "_zero"}, out_zero, ez);
    step();
  endtask

  // ---------------- random instances of other shapes ----------------
  localparam int NCFG = 3;
  localparam int CW [NCFG] = '{4, 8, 32};
  localparam int CG [NCFG] = '{4, 2, 8};
  logic cfg_done [NCFG];

  for (genvar ci = 0; ci < NCFG; ci++) begin : g_cfg
    localparam int W  = CW[ci];
    localparam int G  = CG[ci];
    localparam int NG = W / G;
    logic         iv, ir, isb, ov, ordy, oc, oo, oz;
    logic [W-1:0] ia, ib, os;
    logic [34:0]  q[$];
    logic [34:0]  ex;

    cla_pipe_addsub #(.WIDTH(W), .GROUP(G)) u_dut (
      .clk(clk), .rst(rst_c),
      .in_valid(iv), .in_ready(ir), .in_a(ia), .in_b(ib), .in_sub(isb),
      .out_valid(ov), .out_ready(ordy), .out_sum(os),
      .out_cout(oc), .out_ovf(oo), .out_zero(oz)
    );

    always @(negedge clk) begin
      if (rst_c) begin
        q.delete();
      end else begin
        chk($sformatf("cfg%0d_in_ready", ci), ir, !(ov && !ordy));
        if (iv && ir) q.push_back(model(W, 32'(ia), 32'(ib), isb));
        if (ov && ordy) begin
          if (q.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL cfg%0d_spurious: got sum 0x%0h, expected no result", ci, os);
          end else begin
            ex = q.pop_front();
            chk($sformatf("cfg%0d_result", ci), {32'(os), oc, oo, oz}, ex);
          end
        end
      end
    end

    initial begin
      int lat;
      cfg_done[ci] = 1'b0;
      iv = 1'b0; ia = '0; ib = '0; isb = 1'b0; ordy = 1'b1;
      wait (rst_c == 1'b0);
      step();
      // all-ones + 1: full carry chain, result zero, latency equals group count
      ia = '1; ib = W'(1); isb = 1'b0; iv = 1'b1;
      step();
      iv = 1'b0;
      lat = 1;
      while (!ov && lat < 40) begin
        step();
        lat++;
      end
      chk($sformatf("cfg%0d_latency", ci), lat, NG);
      chk($sformatf("cfg%0d_carry_sum", ci), {oc, os}, {1'b1, W'(0)});
      chk($sformatf("cfg%0d_zero", ci), oz, 1'b1);
      step();
      for (int i = 0; i < 250; i++) begin
        iv   = ($urandom_range(0, 3) != 0);
        ia   = W'($urandom());
        ib   = W'($urandom());
        isb  = 1'($urandom_range(0, 1));
        ordy = ($urandom_range(0, 3) != 0);
        step();
      end
      iv = 1'b0; ordy = 1'b1;
      repeat (NG + 4) step();
      chk($sformatf("cfg%0d_drain", ci), q.size(), 0);
      cfg_done[ci] = 1'b1;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int idx, n0, cnt;
    logic go, all_done;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b1;

    chk("model_pin_add",    model(16, 32'hFFFF, 32'h0001, 1'b0), {32'h0000, 1'b1, 1'b0, 1'b1});
    chk("model_pin_ovf",    model(16, 32'h8000, 32'h0001, 1'b1), {32'h7FFF, 1'b1, 1'b1, 1'b0});
    chk("model_pin_borrow", model(16, 32'h0003, 32'h0005, 1'b1), {32'hFFFE, 1'b0, 1'b0, 1'b0});
    chk("model_pin_legacy", model(4,  32'hF,    32'h1,    1'b0), {32'h0,    1'b1, 1'b0, 1'b1});

    repeat (3) step();
    chk("reset_outputs", {out_valid, out_sum, out_cout, out_ovf, out_zero}, 20'h0);
    rst = 1'b0; rst_c = 1'b0;
    #1;
    chk("reset_in_ready", in_ready, 1'b1);
    step();

    directed("add_carry",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    directed("sub_ovf",    16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    directed("sub_borrow", 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    directed("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    directed("add_plain",  16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
    directed("sub_equal",  16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);

    // six back-to-back beats, consumer stalls three cycles mid-stream
    n0 = ndone;
    idx = 0;
    for (int cyc = 0; cyc < 40 && (idx < 6 || q16.size() != 0 || out_valid); cyc++) begin
      out_ready = !(cyc >= 5 && cyc < 8);
      if (idx < 6) begin
        in_valid = 1'b1;
        in_a = 16'h1111 * 16'(idx) + 16'h0F0F;
        in_b = 16'h2222 ^ 16'(idx);
        in_sub = idx[0];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      go = in_valid && in_ready;
      step();
      if (go) idx++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_delivered", ndone - n0, 6);

    // reset with one result at the output and three beats behind it
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_a = 16'h0100 + 16'(i); in_b = 16'h0010; in_sub = 1'b0;
      step();
    end
    in_valid = 1'b0;
    chk("pre_rst_valid", out_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_flush_valid", out_valid, 1'b0);
    chk("rst_flush_sum", out_sum, 16'h0);
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("no_stale", out_valid, 1'b0);
    end
    directed("post_rst", 16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);

    // full rate: continuous valid with ready high must give one result per cycle
    repeat (5) step();
    cnt = 0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      in_a = 16'($urandom()); in_b = 16'($urandom()); in_sub = 1'($urandom_range(0, 1));
      step();
      if (out_valid) cnt++;
    end
    in_valid = 1'b0;
    chk("throughput", cnt, 21);

    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = 16'($urandom());
      in_b      = 16'($urandom());
      in_sub    = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) step();
    chk("drain_main", q16.size(), 0);

    all_done = 1'b0;
    for (int t = 0; t < 5000 && !all_done; t++) begin
      all_done = cfg_done[0] && cfg_done[1] && cfg_done[2];
      if (!all_done) step();
    end
    if (!all_done) begin
      nvec++;
      nerr++;
      $display("FAIL cfg_timeout: got unfinished instances, expected all done");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
